// File: rtl/acc_arbiter_pkg.sv
// Shared types and defaults for the accumulating two-port arbiter.
package acc_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV   = 2;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } state_t;

  typedef enum logic {
    OWNER_A,
    OWNER_B
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the side not granted last wins a tie.
module rr_arb2
  import acc_arbiter_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_t last,
  output logic   gnt_a,
  output logic   gnt_b
);

  assign gnt_a = req_a & (~req_b | (last == OWNER_B));
  assign gnt_b = req_b & (~req_a | (last == OWNER_A));

endmodule

// File: rtl/acc_arbiter.sv
// Prescaled round-robin arbiter feeding a shared accumulator.
// Define ACC_ARBITER_SAT_EN to saturate the add instead of wrapping.
module acc_arbiter
  import acc_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  owner_t           r_last;
  logic [WIDTH-1:0] r_y;
  logic             r_ovf;

  logic             w_arb_a;
  logic             w_arb_b;
  logic             w_in_grant;
  logic             w_any_req;
  logic [WIDTH-1:0] w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_ovf_nxt;

  rr_arb2 u_rr (
    .req_a (req_a),
    .req_b (req_b),
    .last  (r_last),
    .gnt_a (w_arb_a),
    .gnt_b (w_arb_b)
  );

  assign w_any_req  = req_a | req_b;
  assign w_in_grant = (r_state == GRANT);
  assign gnt_a      = w_in_grant & w_arb_a;
  assign gnt_b      = w_in_grant & w_arb_b;

  assign w_op  = gnt_a ? a : b;
  assign w_sum = {1'b0, r_y} + {1'b0, w_op};

`ifdef ACC_ARBITER_SAT_EN
  assign w_y_nxt = w_sum[WIDTH] ? {WIDTH{1'b1}}
                                : w_sum[WIDTH-1:0];
`else
  assign w_y_nxt = w_sum[WIDTH-1:0];
`endif

  assign w_ovf_nxt = r_ovf | w_sum[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= OWNER_B;
      r_y     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (!w_any_req) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= GRANT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GRANT: begin
          r_state <= IDLE;
          if (gnt_a) r_last <= OWNER_A;
          else if (gnt_b) r_last <= OWNER_B;
        end
        default: r_state <= IDLE;
      endcase

      // clr wins over a same-cycle add; the grant still consumes the operand
      if (clr) begin
        r_y   <= '0;
        r_ovf <= 1'b0;
      end else if (gnt_a | gnt_b) begin
        r_y   <= w_y_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign y   = r_y;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_acc_arbiter.sv
// Scoreboard bench for acc_arbiter at WIDTH=4, DIV=2.
module tb_acc_arbiter;

`ifdef ACC_ARBITER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] a     = 4'd0;
  logic [3:0] b     = 4'd0;
  logic       gnt_a;
  logic       gnt_b;
  logic       ovf;
  logic [3:0] y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic is_a;
    int   y;
    int   ovf;
    int   cyc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acc_arbiter #(.WIDTH(4), .DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (req_a),
    .a     (a),
    .req_b (req_b),
    .b     (b),
    .clr   (clr),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .y     (y),
    .ovf   (ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic is_a, input int ey,
                      input int eo, input int ec);
    exp_t e;
    e.is_a = is_a;
    e.y    = ey;
    e.ovf  = eo;
    e.cyc  = ec;
    q.push_back(e);
  endtask

  task automatic wait_gnt(input logic is_a, input int clr_cyc,
                          input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk);
      #1;
      clr = (cyc == clr_cyc);
      if (is_a ? gnt_a : gnt_b) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no grant expected grant in 30 cycles", nm);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    if (is_a) req_a = 1'b0;
    else req_b = 1'b0;
  endtask

  task automatic single(input logic is_a, input logic [3:0] v,
                        input int ey, input int eo,
                        input bit clr_g, input string nm);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (is_a) begin
      a = v;
      req_a = 1'b1;
    end else begin
      b = v;
      req_b = 1'b1;
    end
    push(is_a, ey, eo, c0 + 3);
    wait_gnt(is_a, clr_g ? c0 + 3 : -1, nm);
  endtask

  task automatic contention(input logic [3:0] av, input logic [3:0] bv,
                            input int ya, input int yb);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    a = av;
    b = bv;
    req_a = 1'b1;
    req_b = 1'b1;
    push(1'b1, ya, 0, c0 + 3);
    push(1'b0, yb, 0, c0 + 7);
    wait_gnt(1'b1, -1, "cont_a");
    wait_gnt(1'b0, -1, "cont_b");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    fork
      begin : mon
        exp_t e;
        exp_t pe;
        bit pend;
        pend = 1'b0;
        forever begin
          @(negedge clk);
          if (pend) begin
            chk("y_after_gnt", int'(y), pe.y);
            chk("ovf_after_gnt", int'(ovf), pe.ovf);
            pend = 1'b0;
          end
          if (gnt_a || gnt_b) begin
            chk("gnt_exclusive", int'(gnt_a & gnt_b), 0);
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_gnt: got gnt_a=%0b gnt_b=%0b expected none",
                       gnt_a, gnt_b);
            end else begin
              e = q.pop_front();
              chk("gnt_owner_a", int'(gnt_a), int'(e.is_a));
              chk("gnt_cycle", cyc, e.cyc);
              pe = e;
              pend = 1'b1;
            end
          end
        end
      end
    join_none

    #2;
    chk("rst_y", int'(y), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_gnt_b", int'(gnt_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    single(1'b1, 4'd3, 3, 0, 1'b0, "lat_a3");

    do_reset();
    contention(4'd1, 4'd2, 1, 3);

    single(1'b1, 4'd11, 14, 0, 1'b0, "to14");
    single(1'b0, 4'd5, SAT ? 15 : 3, 1, 1'b0, "carry");
    single(1'b1, 4'd1, SAT ? 15 : 4, 1, 1'b0, "sticky");

    begin : drop
      bit seen;
      seen = 1'b0;
      @(posedge clk);
      #1;
      a = 4'd2;
      req_a = 1'b1;
      @(posedge clk);
      #1;
      req_a = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen = seen | gnt_a | gnt_b;
      end
      chk("drop_no_gnt", int'(seen), 0);
      chk("drop_y", int'(y), SAT ? 15 : 4);
      chk("drop_ovf", int'(ovf), 1);
    end

    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_y", int'(y), 0);
    chk("clr_ovf", int'(ovf), 0);

    single(1'b1, 4'd9, 9, 0, 1'b0, "to9");
    single(1'b1, 4'd4, 0, 0, 1'b1, "clr_in_grant");

    single(1'b1, 4'd12, 12, 0, 1'b0, "to12");
    single(1'b1, 4'd6, SAT ? 15 : 2, 1, 1'b0, "ovf_set");

    @(posedge clk);
    #1;
    a = 4'd1;
    b = 4'd2;
    req_a = 1'b1;
    req_b = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_y", int'(y), 0);
    chk("midwait_rst_ovf", int'(ovf), 0);
    chk("midwait_rst_gnt_a", int'(gnt_a), 0);
    chk("midwait_rst_gnt_b", int'(gnt_b), 0);
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    contention(4'd1, 4'd2, 1, 3);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_arbiter.md
ACC_ARBITER -- requirements
Module: acc_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand, accumulator and y width in bits.
REQ-002 Parameter DIV, default 2, legal range 1..16: prescale cycles spent in WAIT before each grant slot.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_a  input  1  requester A wants an add; held high until gnt_a.
REQ-006 a  input  WIDTH  requester A operand; held stable while req_a is high.
REQ-007 req_b  input  1  requester B wants an add; held high until gnt_b.
REQ-008 b  input  WIDTH  requester B operand; held stable while req_b is high.
REQ-009 clr  input  1  synchronous clear of y and ovf.
REQ-010 gnt_a  output  1  one-cycle pulse; A's operand is consumed this cycle.
REQ-011 gnt_b  output  1  one-cycle pulse; B's operand is consumed this cycle.
REQ-012 y  output  WIDTH  accumulator value, registered.
REQ-013 ovf  output  1  sticky overflow flag, registered.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and GRANT.
REQ-015 IDLE: if req_a|req_b, go to WAIT with prescale count=0; else stay in IDLE.
REQ-016 WAIT: count increments each cycle.
- count==DIV-1 -> GRANT.
- req_a and req_b both low -> IDLE, with no grant issued.
REQ-017 GRANT: lasts exactly one cycle, then IDLE unconditionally.
REQ-018 GRANT winner uses req sampled in the GRANT cycle.
- Single requester wins.
- Both requesting: the requester not granted last wins.
- Neither requesting: no gnt.
REQ-019 gnt_a/gnt_b SHALL be high only in GRANT, mutually exclusive, and combinational from state and the arbiter decision.
REQ-020 Latency: req first sampled in IDLE at cycle 0 -> gnt in cycle DIV+1 -> updated y visible in cycle DIV+2.
REQ-021 On a grant, y <= y + winner operand at the end of the GRANT cycle; the last-granted pointer updates at the same edge.
REQ-022 Default (wrap) arithmetic: the sum is taken modulo 2^WIDTH; a carry-out sets ovf.
REQ-023 ovf stays set until clr or reset.
REQ-024 clr has priority over an add in the same cycle: y<=0 and ovf<=0.
- A gnt in that cycle still pulses; its operand is discarded.
REQ-025 clr SHALL NOT affect FSM state, prescale count or the last-granted pointer.
REQ-026 A requester whose req stays high after its gnt SHALL be treated as a new request from the next IDLE.

Reset
REQ-027 rst_n low SHALL immediately force:
- state=IDLE, count=0;
- y=0, ovf=0, gnt_a=gnt_b=0;
- last-granted pointer=B, so A wins the first contention.
REQ-028 Reset asserted mid-WAIT or mid-GRANT SHALL abort the operation with no accumulator update.

Configuration
REQ-029 Macro ACC_ARBITER_SAT_EN: when defined, the add SHALL saturate at 2^WIDTH-1 and set ovf on saturation; when undefined, wrap arithmetic per REQ-022 applies.

Structure
REQ-030 Package acc_arbiter_pkg SHALL hold:
- the FSM state enum (IDLE/WAIT/GRANT);
- the default WIDTH and DIV constants;
- the grant-owner enum (OWNER_A/OWNER_B).
REQ-031 Round-robin decision SHALL be the sub-module rr_arb2: inputs req_a, req_b, last owner; outputs gnt_a, gnt_b.

Verification (WIDTH=4, DIV=2)
REQ-032 Reset, then req_a=1, a=3 from cycle 0 -> gnt_a pulses in cycle 3 only; y=3 from cycle 4; ovf=0.
REQ-033 req_a=1 with a=1 and req_b=1 with b=2, both held until granted -> gnt_a first with y=1, gnt_b on the next slot with y=3; never both high.
REQ-034 y=14, req_b with b=5 -> y=3, ovf=1 (wrap); with ACC_ARBITER_SAT_EN defined -> y=15, ovf=1.
REQ-035 req_a dropped in the first WAIT cycle -> FSM returns to IDLE, no gnt, y unchanged.
REQ-036 y=9, clr=1 in the GRANT cycle of a=4 -> gnt_a pulses, y=0, ovf=0.
REQ-037 rst_n low mid-WAIT -> state, y, ovf and gnt all zero before the next clock edge; a later contention grants A first.
